// File: rtl/div16x8_seq_ctrl.sv
// Sequential 16/8 restoring divider: one shared 9-bit restoring row is reused for
// 8 cycles. An optional approximate LSB-cell schedule is selected per request.
module div16x8_seq_ctrl #(
  parameter int APPROX_ROWS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [7:0]  y,
  input  logic        approx_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  q,
  output logic [7:0]  r,
  output logic        ovf,
  output logic        dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  p_q, p_d;
  logic [6:0]  xs_q, xs_d;
  logic [7:0]  y_q, y_d;
  logic        approx_q, approx_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  r_q, r_d;

  logic        accept_s;
  logic [7:0]  approx_cell_s;
  logic [8:0]  borrow_s;
  logic [7:0]  rout_s;
  logic        qs_s;

  assign accept_s = in_valid & (state_q == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_RUN;
        else          state_d = S_IDLE;
      end
      S_RUN: begin
        if (j_q == 3'd0) state_d = S_DONE;
        else             state_d = S_RUN;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    q         = q_q;
    r         = r_q;
    ovf       = ovf_q;
    dz        = dz_q;
  end

  // Shared restoring row; the borrow chain must settle before qs selects each rout
  always_comb begin
    approx_cell_s = 8'h00;
    borrow_s      = 9'h000;
    rout_s        = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (approx_q && (int'(j_q) < APPROX_ROWS) && (k < (APPROX_ROWS - int'(j_q)))) begin
        approx_cell_s[k] = 1'b1;
      end else begin
        approx_cell_s[k] = 1'b0;
      end
      if (approx_cell_s[k]) begin
        borrow_s[k+1] = borrow_s[k] & (y_q[k] | ~p_q[k]);
      end else begin
        borrow_s[k+1] = (~p_q[k] & borrow_s[k]) | (~p_q[k] & y_q[k]) | (y_q[k] & borrow_s[k]);
      end
    end
    qs_s = ~borrow_s[8] | p_q[8];
    for (int k = 0; k < 8; k++) begin
      if (approx_cell_s[k]) begin
        rout_s[k] = p_q[k] | (qs_s & (y_q[k] ^ borrow_s[k]));
      end else if (qs_s) begin
        rout_s[k] = p_q[k] ^ y_q[k] ^ borrow_s[k];
      end else begin
        rout_s[k] = p_q[k];
      end
    end
  end

  // Datapath next values: load on accept, one quotient row per RUN cycle
  always_comb begin
    p_d      = p_q;
    xs_d     = xs_q;
    y_d      = y_q;
    approx_d = approx_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    j_d      = j_q;
    q_d      = q_q;
    r_d      = r_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          p_d      = x[15:7];
          xs_d     = x[6:0];
          y_d      = y;
          approx_d = approx_en;
          ovf_d    = (x[15:8] >= y);
          dz_d     = (y == 8'h00);
          j_d      = 3'd7;
          q_d      = 8'h00;
        end else begin
          j_d = j_q;
        end
      end
      S_RUN: begin
        q_d[j_q] = qs_s;
        if (j_q != 3'd0) begin
          p_d  = {rout_s, xs_q[6]};
          xs_d = {xs_q[5:0], 1'b0};
          j_d  = j_q - 3'd1;
        end else begin
          r_d = rout_s;
        end
      end
      S_DONE: begin
        j_d = j_q;
      end
      default: begin
        j_d = 3'd0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= 9'h000;
      xs_q     <= 7'h00;
      y_q      <= 8'h00;
      approx_q <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      j_q      <= 3'd0;
      q_q      <= 8'h00;
      r_q      <= 8'h00;
    end else begin
      p_q      <= p_d;
      xs_q     <= xs_d;
      y_q      <= y_d;
      approx_q <= approx_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      j_q      <= j_d;
      q_q      <= q_d;
      r_q      <= r_d;
    end
  end

endmodule
